// File: rtl/cmsdk_ahb_bm_pkg.sv
// Shared AHB bus-matrix encodings and the address-phase record used by the
// per-master input stages.
package cmsdk_ahb_bm_pkg;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BUR_SINGLE = 3'b000,
    BUR_INCR   = 3'b001,
    BUR_WRAP4  = 3'b010,
    BUR_INCR4  = 3'b011,
    BUR_WRAP8  = 3'b100,
    BUR_INCR8  = 3'b101,
    BUR_WRAP16 = 3'b110,
    BUR_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    RSP_OKAY  = 2'b00,
    RSP_ERROR = 2'b01,
    RSP_RETRY = 2'b10,
    RSP_SPLIT = 2'b11
  } hresp_t;

  // Address-phase control fields; the address is added per instance so it
  // can follow ADDR_WIDTH.
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } aph_ctrl_t;

  // Bit 1 = transfer pending in the hold register, bit 0 = data phase open.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PEND = 2'b10
  } hold_state_t;

endpackage

// File: rtl/cmsdk_ahb_bm_input_hold_if.sv
// Signal bundle between one AHB master port, its input stage and the
// output-port arbiters of the bus matrix.
interface cmsdk_ahb_bm_input_hold_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  addr_accept;
  logic                  data_ready;
  logic [1:0]            data_resp;

  logic                  req_out;
  logic                  sel_out;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [1:0]            trans_out;
  logic                  write_out;
  logic [2:0]            size_out;
  logic [2:0]            burst_out;
  logic [3:0]            prot_out;
  logic                  lock_out;
  logic                  HREADYOUTS;
  logic [1:0]            HRESPS;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, addr_accept, data_ready, data_resp,
    output req_out, sel_out, addr_out, trans_out, write_out, size_out,
           burst_out, prot_out, lock_out, HREADYOUTS, HRESPS
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, addr_accept, data_ready, data_resp,
    input  req_out, sel_out, addr_out, trans_out, write_out, size_out,
           burst_out, prot_out, lock_out, HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/cmsdk_ahb_bm_input_hold.sv
// Bus-matrix input stage: holds a blocked address phase, replays it to the
// arbiter until granted, and stalls the master until it completes.
module cmsdk_ahb_bm_input_hold
  import cmsdk_ahb_bm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  cmsdk_ahb_bm_input_hold_if.slave      bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    aph_ctrl_t             ctrl;
  } aphase_t;

  hold_state_t state_q, state_d;
  aphase_t     hold_q, hold_d;
  aphase_t     live, fwd;
  logic        fwd_sel, fwd_req;
  logic        pend, live_valid, capture, accept_xfer;

  assign pend        = (state_q == ST_PEND);
  assign live_valid  = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign capture     = live_valid & ~bus.addr_accept & ~pend;
  assign accept_xfer = fwd_req & bus.addr_accept & bus.data_ready & fwd.ctrl.trans[1];

  always_comb begin
    live.addr       = bus.HADDRS;
    live.ctrl.trans = bus.HTRANSS;
    live.ctrl.write = bus.HWRITES;
    live.ctrl.size  = bus.HSIZES;
    live.ctrl.burst = bus.HBURSTS;
    live.ctrl.prot  = bus.HPROTS;
    live.ctrl.lock  = bus.HMASTLOCKS;
  end

  // Hold register and forwarding mux
  always_comb begin
    hold_d = capture ? live : hold_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hold_q <= '0;
    else          hold_q <= hold_d;
  end

  always_comb begin
    fwd     = live;
    fwd_sel = 1'b0;
    if (pend) begin
      fwd     = hold_q;
      fwd_sel = 1'b1;
    end else if (bus.HSELS && bus.HREADYS) begin
      fwd_sel = 1'b1;
    end else begin
      fwd.ctrl.trans = TRN_IDLE;
    end
    // A locked IDLE still requests so the lock reaches the arbiter.
    fwd_req = fwd_sel & (fwd.ctrl.trans[1] | fwd.ctrl.lock);
  end

  assign bus.req_out   = fwd_req;
  assign bus.sel_out   = fwd_sel;
  assign bus.addr_out  = fwd.addr;
  assign bus.trans_out = fwd.ctrl.trans;
  assign bus.write_out = fwd.ctrl.write;
  assign bus.size_out  = fwd.ctrl.size;
  assign bus.burst_out = fwd.ctrl.burst;
  assign bus.prot_out  = fwd.ctrl.prot;
  assign bus.lock_out  = fwd.ctrl.lock;

  // Transfer state machine
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_xfer)  state_d = ST_DATA;
        else if (capture) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (bus.addr_accept && bus.data_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Back-to-back accept keeps the data phase open.
        if (accept_xfer)         state_d = ST_DATA;
        else if (bus.data_ready) state_d = capture ? ST_PEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.HREADYOUTS = 1'b1;
    bus.HRESPS     = RSP_OKAY;
    unique case (state_q)
      ST_DATA: begin
        bus.HREADYOUTS = bus.data_ready;
        bus.HRESPS     = bus.data_resp;
      end
      ST_PEND: bus.HREADYOUTS = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cmsdk_ahb_bm_input_hold.sv
// Bench for the bus-matrix input stage: directed vector table, reset corner
// sequences and random traffic against a rule-level reference model.
module tb_cmsdk_ahb_bm_input_hold;
  import cmsdk_ahb_bm_pkg::*;

  localparam int AW = 32;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  cmsdk_ahb_bm_input_hold_if #(.ADDR_WIDTH(AW)) bus ();

  cmsdk_ahb_bm_input_hold #(.ADDR_WIDTH(AW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [AW-1:0] addr,
                       input logic write, input logic [2:0] size, input logic [2:0] burst,
                       input logic [3:0] prot, input logic lock, input logic hrdy,
                       input logic acc, input logic dr, input logic [1:0] resp);
    bus.HSELS       = sel;
    bus.HTRANSS     = trans;
    bus.HADDRS      = addr;
    bus.HWRITES     = write;
    bus.HSIZES      = size;
    bus.HBURSTS     = burst;
    bus.HPROTS      = prot;
    bus.HMASTLOCKS  = lock;
    bus.HREADYS     = hrdy;
    bus.addr_accept = acc;
    bus.data_ready  = dr;
    bus.data_resp   = resp;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'b00, '0, 1'b0, 3'b000, 3'b000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        lock;
    logic        write;
    logic [31:0] addr;
    logic        hrdy;
    logic        acc;
    logic        dr;
    logic [1:0]  resp;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic        e_req;
    logic [1:0]  e_trans;
    logic        chk_addr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[19];

  // Reference model state: a pending held transfer and an open data phase.
  bit          m_pend, m_dph;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write, h_lock;
  logic [2:0]  h_size, h_burst;
  logic [3:0]  h_prot;

  initial begin
    // idle / direct pass / blocked / error / INCR4 with BUSY / locked idle
    vt[0]  = '{0,2'd0,0,0,32'h0,          1,0,1,2'd0, 1,2'd0,0,2'd0, 0,32'h0};
    vt[1]  = '{1,2'd2,0,0,32'h2000_0000,  1,1,1,2'd0, 1,2'd0,1,2'd2, 1,32'h2000_0000};
    vt[2]  = '{0,2'd0,0,0,32'h0,          1,0,1,2'd0, 1,2'd0,0,2'd0, 0,32'h0};
    vt[3]  = '{1,2'd2,0,1,32'h4000_0010,  1,0,1,2'd0, 1,2'd0,1,2'd2, 1,32'h4000_0010};
    vt[4]  = '{1,2'd2,0,1,32'h5555_0000,  0,0,1,2'd0, 0,2'd0,1,2'd2, 1,32'h4000_0010};
    vt[5]  = '{1,2'd2,0,1,32'h5555_0000,  0,0,1,2'd0, 0,2'd0,1,2'd2, 1,32'h4000_0010};
    vt[6]  = '{1,2'd2,0,1,32'h5555_0000,  0,1,1,2'd0, 0,2'd0,1,2'd2, 1,32'h4000_0010};
    vt[7]  = '{0,2'd0,0,0,32'h0,          1,0,1,2'd0, 1,2'd0,0,2'd0, 0,32'h0};
    vt[8]  = '{1,2'd2,0,0,32'h6000_0000,  1,1,1,2'd0, 1,2'd0,1,2'd2, 1,32'h6000_0000};
    vt[9]  = '{0,2'd0,0,0,32'h0,          0,0,0,2'd1, 0,2'd1,0,2'd0, 0,32'h0};
    vt[10] = '{0,2'd0,0,0,32'h0,          1,0,1,2'd1, 1,2'd1,0,2'd0, 0,32'h0};
    vt[11] = '{1,2'd2,0,0,32'h0000_0100,  1,1,1,2'd0, 1,2'd0,1,2'd2, 1,32'h0000_0100};
    vt[12] = '{1,2'd3,0,0,32'h0000_0104,  1,1,1,2'd0, 1,2'd0,1,2'd3, 1,32'h0000_0104};
    vt[13] = '{1,2'd1,0,0,32'h0000_0108,  1,1,1,2'd0, 1,2'd0,0,2'd1, 1,32'h0000_0108};
    vt[14] = '{1,2'd3,0,0,32'h0000_0108,  1,1,1,2'd0, 1,2'd0,1,2'd3, 1,32'h0000_0108};
    vt[15] = '{1,2'd3,0,0,32'h0000_010C,  1,1,1,2'd0, 1,2'd0,1,2'd3, 1,32'h0000_010C};
    vt[16] = '{0,2'd0,0,0,32'h0,          1,0,1,2'd0, 1,2'd0,0,2'd0, 0,32'h0};
    vt[17] = '{1,2'd0,1,0,32'h0000_0200,  1,0,1,2'd0, 1,2'd0,1,2'd0, 1,32'h0000_0200};
    vt[18] = '{0,2'd0,0,0,32'h0,          1,0,1,2'd0, 1,2'd0,0,2'd0, 0,32'h0};

    // Reset state
    HRESETn = 1'b0;
    drive_idle();
    #2;
    chk("reset HREADYOUTS", bus.HREADYOUTS, 1);
    chk("reset HRESPS",     bus.HRESPS,     0);
    chk("reset req_out",    bus.req_out,    0);
    chk("reset trans_out",  bus.trans_out,  0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    chk("release HREADYOUTS", bus.HREADYOUTS, 1);
    chk("release req_out",    bus.req_out,    0);

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].sel, vt[i].trans, vt[i].addr, vt[i].write, 3'b010, 3'b011, 4'h3,
            vt[i].lock, vt[i].hrdy, vt[i].acc, vt[i].dr, vt[i].resp);
      #1;
      chk($sformatf("row%0d HREADYOUTS", i), bus.HREADYOUTS, vt[i].e_rdy);
      chk($sformatf("row%0d HRESPS", i),     bus.HRESPS,     vt[i].e_resp);
      chk($sformatf("row%0d req_out", i),    bus.req_out,    vt[i].e_req);
      chk($sformatf("row%0d trans_out", i),  bus.trans_out,  vt[i].e_trans);
      if (vt[i].chk_addr) chk($sformatf("row%0d addr_out", i), bus.addr_out, vt[i].e_addr);
      @(negedge HCLK);
    end

    // Reset while a transfer is held
    drive(1'b1, 2'b10, 32'h7000_0040, 1'b1, 3'b010, 3'b000, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    @(negedge HCLK);
    drive(1'b1, 2'b10, 32'h7000_0040, 1'b1, 3'b010, 3'b000, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    #1;
    chk("pend req_out",    bus.req_out,    1);
    chk("pend HREADYOUTS", bus.HREADYOUTS, 0);
    chk("pend addr_out",   bus.addr_out,   32'h7000_0040);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("rst-pend req_out",    bus.req_out,    0);
    chk("rst-pend HREADYOUTS", bus.HREADYOUTS, 1);
    chk("rst-pend trans_out",  bus.trans_out,  0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive_idle();
    #1;
    chk("after-rst req_out", bus.req_out, 0);
    @(negedge HCLK);
    #1;
    chk("after-rst replay req_out",    bus.req_out,    0);
    chk("after-rst replay HREADYOUTS", bus.HREADYOUTS, 1);
    @(negedge HCLK);

    // Random traffic against the reference model
    m_pend = 0; m_dph = 0;
    h_addr = '0; h_trans = 2'b00; h_write = 0; h_lock = 0;
    h_size = '0; h_burst = '0; h_prot = '0;
    for (int c = 0; c < 3000; c++) begin
      logic        sel, lock, write, acc, dr, hrdy, live_valid;
      logic [1:0]  trans, resp;
      logic [2:0]  size, burst;
      logic [3:0]  prot;
      logic [31:0] addr;
      logic        e_sel, e_req, e_rdy, e_write, e_lock;
      logic [1:0]  e_trans, e_resp;
      logic [2:0]  e_size, e_burst;
      logic [3:0]  e_prot;
      logic [31:0] e_addr;
      bit          take, done;

      sel   = ($urandom_range(0, 3) != 0);
      trans = 2'($urandom_range(0, 3));
      lock  = ($urandom_range(0, 7) == 0);
      write = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 7));
      burst = 3'($urandom_range(0, 7));
      prot  = 4'($urandom_range(0, 15));
      addr  = $urandom;
      acc   = ($urandom_range(0, 2) != 0);
      dr    = ($urandom_range(0, 3) != 0);
      resp  = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00;

      // Master-side HREADY is the bus HREADY this stage returns.
      e_rdy  = m_dph ? dr : !m_pend;
      e_resp = m_dph ? resp : 2'b00;
      hrdy   = e_rdy;
      live_valid = sel & trans[1] & hrdy;

      if (m_pend) begin
        e_sel = 1; e_addr = h_addr; e_trans = h_trans; e_write = h_write;
        e_size = h_size; e_burst = h_burst; e_prot = h_prot; e_lock = h_lock;
      end else begin
        e_sel = sel & hrdy; e_addr = addr; e_trans = e_sel ? trans : 2'b00;
        e_write = write; e_size = size; e_burst = burst; e_prot = prot; e_lock = lock;
      end
      e_req = e_sel & (e_trans[1] | e_lock);

      drive(sel, trans, addr, write, size, burst, prot, lock, hrdy, acc, dr, resp);
      #1;
      chk("rnd req_out",    bus.req_out,    e_req);
      chk("rnd sel_out",    bus.sel_out,    e_sel);
      chk("rnd trans_out",  bus.trans_out,  e_trans);
      chk("rnd HREADYOUTS", bus.HREADYOUTS, e_rdy);
      chk("rnd HRESPS",     bus.HRESPS,     e_resp);
      if (e_sel) begin
        chk("rnd addr_out",  bus.addr_out,  e_addr);
        chk("rnd write_out", bus.write_out, e_write);
        chk("rnd size_out",  bus.size_out,  e_size);
        chk("rnd burst_out", bus.burst_out, e_burst);
        chk("rnd prot_out",  bus.prot_out,  e_prot);
        chk("rnd lock_out",  bus.lock_out,  e_lock);
      end

      @(posedge HCLK);
      take = e_req & acc & dr & e_trans[1];
      if (m_pend) begin
        done = acc & dr;
        if (done) m_pend = 0;
      end else if (live_valid && !acc) begin
        m_pend = 1;
        h_addr = addr; h_trans = trans; h_write = write; h_lock = lock;
        h_size = size; h_burst = burst; h_prot = prot;
      end
      if (take)    m_dph = 1;
      else if (dr) m_dph = 0;
      @(negedge HCLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
